// File: rtl/frame_unloader_if.sv
// Handshake bundle for the frame unloader: one frame-wide input channel
// and one word-wide streaming output channel with first/last markers.
interface frame_unloader_if #(
  parameter int W = 3,
  parameter int N = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_first;
  logic             out_last;
  logic             busy;

  // Side that offers frames and consumes words.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last, busy
  );

  // The unloader itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last, busy
  );
endinterface

// File: rtl/frame_unloader.sv
// Parallel-in, serial-out frame unloader. Takes one N-word frame in a single
// handshake, then streams the words out LSB word first with first/last markers.
// A new frame may be taken on the handshake of the last word, so consecutive
// frames stream without a bubble. in_ready is the only combinational output.
module frame_unloader #(
  parameter int W = 3,
  parameter int N = 5
) (
  input  logic               clk,
  input  logic               rstn,
  frame_unloader_if.slave    bus
);

  localparam int              IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);
  localparam logic            N_IS_ONE = (LAST_IDX == IW'(0));

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_r;
  logic [N*W-1:0]     shreg_r;
  logic [IW-1:0]      index_r;
  logic               out_valid_r;
  logic [W-1:0]       out_data_r;
  logic               out_first_r;
  logic               out_last_r;

  logic [N*W-1:0]     shreg_shifted_s;
  logic               at_last_s;
  logic               out_hs_s;

  // Zero fill on the shift keeps out_data defined once the frame is drained.
  assign shreg_shifted_s = shreg_r >> W;
  assign at_last_s       = (index_r == LAST_IDX);
  assign out_hs_s        = out_valid_r & bus.out_ready;

  // A frame can be taken when idle, or in the same cycle the last word leaves.
  assign bus.in_ready = (state_r == IDLE) |
                        ((state_r == SHIFT) & at_last_s & bus.out_ready);

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_first = out_first_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = out_valid_r;

  // Frame sequencer: loads, shifts and reloads the frame, registering all outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      shreg_r     <= '0;
      index_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            state_r     <= SHIFT;
            shreg_r     <= bus.in_data;
            index_r     <= '0;
            out_valid_r <= 1'b1;
            out_data_r  <= bus.in_data[W-1:0];
            out_first_r <= 1'b1;
            out_last_r  <= N_IS_ONE;
          end else begin
            state_r     <= IDLE;
          end
        end

        SHIFT: begin
          if (out_hs_s && !at_last_s) begin
            shreg_r     <= shreg_shifted_s;
            index_r     <= index_r + IW'(1);
            out_data_r  <= shreg_shifted_s[W-1:0];
            out_first_r <= 1'b0;
            out_last_r  <= ((index_r + IW'(1)) == LAST_IDX);
          end else if (out_hs_s && bus.in_valid) begin
            // Back-to-back: the next frame replaces the drained one directly.
            shreg_r     <= bus.in_data;
            index_r     <= '0;
            out_data_r  <= bus.in_data[W-1:0];
            out_first_r <= 1'b1;
            out_last_r  <= N_IS_ONE;
          end else if (out_hs_s) begin
            state_r     <= IDLE;
            shreg_r     <= '0;
            index_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
          end else begin
            // Stalled downstream: everything holds.
            state_r     <= SHIFT;
          end
        end

        default: begin
          state_r     <= IDLE;
          shreg_r     <= '0;
          index_r     <= '0;
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
          out_first_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_unloader.sv
// Directed testbench for frame_unloader (W=3, N=5). Inputs change on the
// falling edge; outputs and in_ready are compared 1 ns later, so every check
// sees the values that the following rising edge will act on.
module tb_frame_unloader;

  localparam int W = 3;
  localparam int N = 5;

  localparam logic [N*W-1:0] F_A = 15'h58D1; // words 1,2,3,4,5
  localparam logic [N*W-1:0] F_B = 15'h7FFF; // words 7,7,7,7,7
  localparam logic [N*W-1:0] F_C = 15'h6B1A; // words 2,3,4,5,6

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  frame_unloader_if #(.W(W), .N(N)) bus ();

  frame_unloader #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle's worth of inputs at the falling edge and settle.
  task automatic step(input logic iv, input logic [N*W-1:0] d, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 3'd0 || bus.out_first !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b d=%0d f=%b l=%b b=%b exp all 0",
               bus.out_valid, bus.out_data, bus.out_first, bus.out_last, bus.busy);
    end
    rstn = 1'b1;
    step(1'b0, '0, 1'b0);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    step(1'b1, F_A, 1'b1);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_accept got rdy=%b exp 1", bus.in_ready);
    end
    for (int k = 0; k < N; k++) begin
      step(1'b0, '0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 3'(k + 1) || bus.out_first !== (k == 0) ||
          bus.out_last !== (k == N - 1) || bus.in_ready !== (k == N - 1)) begin
        n_bad++;
        $display("FAIL basic_word k=%0d got v=%b d=%0d f=%b l=%b rdy=%b exp v=1 d=%0d f=%b l=%b rdy=%b",
                 k, bus.out_valid, bus.out_data, bus.out_first, bus.out_last, bus.in_ready,
                 k + 1, (k == 0), (k == N - 1), (k == N - 1));
      end
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 3'd0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle got v=%b d=%0d rdy=%b b=%b exp v=0 d=0 rdy=1 b=0",
               bus.out_valid, bus.out_data, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_stall();
    logic [7:0] pat;
    int wi;
    pat = 8'b1101_1001; // read LSB first: 1,0,0,1,1,0,1,1
    wi  = 0;
    step(1'b1, F_A, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, pat[i]);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 3'(wi + 1) || bus.out_first !== (wi == 0) ||
          bus.out_last !== (wi == N - 1) || bus.in_ready !== ((wi == N - 1) && pat[i])) begin
        n_bad++;
        $display("FAIL stall_word i=%0d got v=%b d=%0d f=%b l=%b rdy=%b exp v=1 d=%0d f=%b l=%b",
                 i, bus.out_valid, bus.out_data, bus.out_first, bus.out_last, bus.in_ready,
                 wi + 1, (wi == 0), (wi == N - 1));
      end
      if (pat[i]) wi++;
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || wi != N) begin
      n_bad++;
      $display("FAIL stall_end got v=%b words=%0d exp v=0 words=%0d", bus.out_valid, wi, N);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, F_A, 1'b1);
    for (int c = 0; c < 2 * N; c++) begin
      step((c < N) ? 1'b1 : 1'b0, F_B, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ((c < N) ? 3'(c + 1) : 3'd7) ||
          bus.out_first !== (c == 0 || c == N) || bus.out_last !== (c == N - 1 || c == 2 * N - 1) ||
          bus.in_ready !== (c == N - 1 || c == 2 * N - 1)) begin
        n_bad++;
        $display("FAIL b2b_word c=%0d got v=%b d=%0d f=%b l=%b rdy=%b",
                 c, bus.out_valid, bus.out_data, bus.out_first, bus.out_last, bus.in_ready);
      end
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end got v=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] exp_d;
    step(1'b1, F_A, 1'b1);
    for (int c = 0; c < 2 * N; c++) begin
      step((c >= 1 && c < N) ? 1'b1 : 1'b0, F_C, 1'b1);
      exp_d = (c < N) ? 3'(c + 1) : 3'(c - N + 2);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_first !== (c == 0 || c == N) ||
          bus.out_last !== (c == N - 1 || c == 2 * N - 1) ||
          bus.in_ready !== (c == N - 1 || c == 2 * N - 1)) begin
        n_bad++;
        $display("FAIL ignore_word c=%0d got v=%b d=%0d f=%b l=%b rdy=%b exp d=%0d",
                 c, bus.out_valid, bus.out_data, bus.out_first, bus.out_last, bus.in_ready, exp_d);
      end
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_end got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, F_A, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    n_cmp++;
    if (bus.out_data !== 3'd3) begin
      n_bad++;
      $display("FAIL areset_pre got d=%0d exp 3", bus.out_data);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 3'd0 || bus.out_first !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_now got v=%b d=%0d f=%b l=%b b=%b exp all 0",
               bus.out_valid, bus.out_data, bus.out_first, bus.out_last, bus.busy);
    end
    step(1'b0, '0, 1'b1);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, '0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 3'd0 || bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL areset_after c=%0d got v=%b d=%0d rdy=%b exp v=0 d=0 rdy=1",
                 c, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset_hold();
    rstn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, F_B, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 3'd0) begin
        n_bad++;
        $display("FAIL rhold_in_reset c=%0d got v=%b d=%0d exp v=0 d=0", c, bus.out_valid, bus.out_data);
      end
    end
    step(1'b1, F_B, 1'b1);
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rhold_release got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    for (int k = 0; k < N; k++) begin
      step(1'b0, '0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 3'd7 || bus.out_first !== (k == 0) ||
          bus.out_last !== (k == N - 1)) begin
        n_bad++;
        $display("FAIL rhold_word k=%0d got v=%b d=%0d f=%b l=%b exp v=1 d=7",
                 k, bus.out_valid, bus.out_data, bus.out_first, bus.out_last);
      end
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rhold_end got v=%b exp 0", bus.out_valid);
    end
  endtask

  // Top-level sequence of directed scenarios.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_ignore_busy();
    test_async_reset();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
